// File: rtl/mesh_node_router.sv
// One 2-D mesh router tile: buffered A/X/Y inputs, fault-aware XY/YX routing, registered
// B/X/Y outputs. Define MESH_NODE_QOS_EN for QoS-first arbitration (default: pure round-robin).
module mesh_node_router #(
  parameter int HP         = 0,
  parameter int VP         = 0,
  parameter int COORD_W    = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = 2 * COORD_W,
  localparam int FLIT_W    = 3 + 2 * ID_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_en,
  input  logic [ID_W-1:0]   pg_node,
  input  logic              a_vld,
  output logic              a_rdy,
  input  logic [FLIT_W-1:0] a_flit,
  input  logic              xi_vld,
  output logic              xi_rdy,
  input  logic [FLIT_W-1:0] xi_flit,
  input  logic              yi_vld,
  output logic              yi_rdy,
  input  logic [FLIT_W-1:0] yi_flit,
  output logic              b_vld,
  input  logic              b_rdy,
  output logic [FLIT_W-1:0] b_flit,
  output logic              xo_vld,
  input  logic              xo_rdy,
  output logic [FLIT_W-1:0] xo_flit,
  output logic              yo_vld,
  input  logic              yo_rdy,
  output logic [FLIT_W-1:0] yo_flit,
  output logic [7:0]        drop_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_W-1:0] SELF_X  = COORD_W'(HP);
  localparam logic [COORD_W-1:0] SELF_Y  = COORD_W'(VP);
  localparam logic [ID_W-1:0]    SELF_ID = {SELF_Y, SELF_X};
  // Route codes double as output indices: 0 = B, 1 = X, 2 = Y.
  localparam logic [1:0] R_B = 2'd0, R_X = 2'd1, R_Y = 2'd2, R_DROP = 2'd3;

  function automatic logic [1:0] route_f(input logic [ID_W-1:0] tgt, input logic fen,
                                         input logic [ID_W-1:0] fnode);
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    tx = tgt[COORD_W-1:0];
    ty = tgt[ID_W-1:COORD_W];
    if (tgt == SELF_ID) return R_B;
    if (fen && tgt == fnode) return R_DROP;
    if (ty == SELF_Y) return R_X;
    if (tx == SELF_X) return R_Y;
    if (fen && {SELF_Y, tx} == fnode) return R_Y;
    return R_X;
  endfunction

  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] g;
    int idx;
    g = '0;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(ptr) + k) % 3;
      if (g == '0 && req[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [2:0] n);
    logic [8:0] s;
    s = {1'b0, c} + 9'(n);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [FLIT_W-1:0] mem_q [3][FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q [3];
  logic [PTR_W-1:0]  rptr_q [3];
  logic [CNT_W-1:0]  cnt_q [3];
  logic [CNT_W-1:0]  cnt_d [3];
  logic [FLIT_W-1:0] in_flit [3];
  logic [FLIT_W-1:0] head [3];
  logic [1:0]        dest [3];
  logic [2:0]        req [3];
  logic [2:0]        gnt [3];
  logic [FLIT_W-1:0] oflit_q [3];
  logic [FLIT_W-1:0] oflit_d [3];
  logic [1:0]        rr_q [3];
  logic [1:0]        rr_d [3];
  logic [2:0]        in_vld, in_rdy, accept, push, pop, head_vld, discard;
  logic [2:0]        ordy, can_load, ovld_q, ovld_d;
  logic [7:0]        drop_q, drop_d;
  logic              a_type_drop, self_failed;
`ifdef MESH_NODE_QOS_EN
  logic [2:0]        req_hi [3];
`endif

  assign self_failed = pg_en && (pg_node == SELF_ID);
  assign in_flit[0]  = a_flit;
  assign in_flit[1]  = xi_flit;
  assign in_flit[2]  = yi_flit;
  assign in_vld      = {yi_vld, xi_vld, a_vld};
  assign ordy        = {yo_rdy, xo_rdy, b_rdy};
  assign a_rdy       = in_rdy[0];
  assign xi_rdy      = in_rdy[1];
  assign yi_rdy      = in_rdy[2];
  assign b_vld       = ovld_q[0] && !self_failed;
  assign xo_vld      = ovld_q[1] && !self_failed;
  assign yo_vld      = ovld_q[2] && !self_failed;
  assign b_flit      = oflit_q[0];
  assign xo_flit     = oflit_q[1];
  assign yo_flit     = oflit_q[2];
  assign drop_cnt    = drop_q;

  // Input stage: FIFO flags, head routing and discards; self_failed freezes everything.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_rdy[i]   = (cnt_q[i] != CNT_W'(FIFO_DEPTH)) && !self_failed;
      accept[i]   = in_vld[i] && in_rdy[i];
      head[i]     = mem_q[i][rptr_q[i]];
      head_vld[i] = (cnt_q[i] != '0) && !self_failed;
      dest[i]     = route_f(head[i][DATA_W +: ID_W], pg_en, pg_node);
      discard[i]  = head_vld[i] && (dest[i] == R_DROP);
    end
    a_type_drop = accept[0] && (a_flit[FLIT_W-2 -: 2] != 2'b00);
    push        = {accept[2], accept[1], accept[0] && !a_type_drop};
  end

  // Output stage: per-output arbitration and register load/drain.
  always_comb begin
    pop = discard;
    for (int o = 0; o < 3; o++) begin
      req[o] = '0;
      for (int i = 0; i < 3; i++) req[o][i] = head_vld[i] && (dest[i] == 2'(o));
`ifdef MESH_NODE_QOS_EN
      req_hi[o] = '0;
      for (int i = 0; i < 3; i++) req_hi[o][i] = req[o][i] && head[i][FLIT_W-1];
      if (req_hi[o] != '0) req[o] = req_hi[o];
`endif
      can_load[o] = (!ovld_q[o] || ordy[o]) && !self_failed;
      gnt[o]      = can_load[o] ? rr_pick(req[o], rr_q[o]) : 3'b000;
      pop         = pop | gnt[o];
      ovld_d[o]   = ovld_q[o];
      oflit_d[o]  = oflit_q[o];
      rr_d[o]     = rr_q[o];
      if (gnt[o] != '0) begin
        ovld_d[o] = 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (gnt[o][i]) begin
            oflit_d[o] = head[i];
            rr_d[o]    = (i == 2) ? 2'd0 : 2'(i + 1);
          end
        end
      end else if (ovld_q[o] && ordy[o] && !self_failed) begin
        ovld_d[o] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    drop_d = sat_add(drop_q, 3'(a_type_drop) + 3'(discard[0]) + 3'(discard[1]) + 3'(discard[2]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]   <= '0;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        oflit_q[i] <= '0;
        rr_q[i]    <= '0;
      end
      ovld_q <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]   <= cnt_d[i];
        oflit_q[i] <= oflit_d[i];
        rr_q[i]    <= rr_d[i];
        if (push[i]) wptr_q[i] <= wptr_q[i] + PTR_W'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PTR_W'(1);
      end
      ovld_q <= ovld_d;
      drop_q <= drop_d;
    end
  end

  // FIFO storage carries no reset; occupancy counters define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_flit[i];
    end
  end
endmodule
